// File: rtl/store_buffer_pkg.sv
// Shared CPU constants for the data-memory store buffer.
//   SB_XLEN  : default data/address width
//   SB_DEPTH : default number of buffered stores (power of 2, >= 2)
package store_buffer_pkg;

   localparam int unsigned SB_XLEN  = 64;
   localparam int unsigned SB_DEPTH = 4;

endpackage

// File: rtl/store_buffer_sb_match.sv
// sb_match: DEPTH-way address compare with youngest-hit select.
//   head       : index of the oldest entry
//   valid      : per-entry valid bits
//   entry_addr : buffered store addresses
//   entry_data : buffered store data
//   addr       : load address to look up
//   hit        : some valid entry matches addr
//   data       : data of the youngest matching entry (0 when no hit)
module sb_match
   import store_buffer_pkg::*;
#(
   parameter int unsigned XLEN  = SB_XLEN,
   parameter int unsigned DEPTH = SB_DEPTH,
   localparam int unsigned PW   = $clog2(DEPTH)
) (
   input  logic [PW-1:0]   head,
   input  logic [DEPTH-1:0] valid,
   input  logic [XLEN-1:0] entry_addr [DEPTH],
   input  logic [XLEN-1:0] entry_data [DEPTH],
   input  logic [XLEN-1:0] addr,
   output logic            hit,
   output logic [XLEN-1:0] data
);

   logic [PW-1:0] idx;

   // Walk from oldest (head) to youngest; a later match overrides an
   // earlier one, so the youngest matching store wins.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (valid[idx] && (entry_addr[idx] == addr)) begin
            hit  = 1'b1;
            data = entry_data[idx];
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of pending stores between CPU data port and
// Data_Mem. Loads are never stalled and own the memory port; idle cycles
// drain the oldest entry. Loads forward from the youngest matching entry.
//   clk, rst                : clock, async active-high reset
//   cpu_req/we/addr/wdata   : CPU access request
//   cpu_rdata               : load data (combinational)
//   cpu_stall               : store not accepted this cycle
//   flush / flush_done      : drain request / flush high and buffer empty
//   mem_addr/wdata/we/rdata : Data_Mem port
//   count                   : current occupancy
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int unsigned XLEN  = SB_XLEN,
   parameter int unsigned DEPTH = SB_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [XLEN-1:0]          cpu_addr,
   input  logic [XLEN-1:0]          cpu_wdata,
   output logic [XLEN-1:0]          cpu_rdata,
   output logic                     cpu_stall,
   input  logic                     flush,
   output logic                     flush_done,
   output logic [XLEN-1:0]          mem_addr,
   output logic [XLEN-1:0]          mem_wdata,
   output logic                     mem_we,
   input  logic [XLEN-1:0]          mem_rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0]    head, tail;
   logic [CW-1:0]    cnt;
   logic [DEPTH-1:0] valid;
   logic [XLEN-1:0]  entry_addr [DEPTH];
   logic [XLEN-1:0]  entry_data [DEPTH];

   logic            is_load, is_store, full, drain, enq;
   logic            fwd_hit;
   logic [XLEN-1:0] fwd_data;

   assign is_load  = cpu_req && !cpu_we;
   assign is_store = cpu_req && cpu_we;
   assign full     = (cnt == CW'(DEPTH));

   // rst is folded in so a reset landing mid-cycle kills the write strobe
   // immediately rather than waiting for the registers to settle.
   assign drain = !is_load && (cnt != '0) && !rst;
   assign enq   = is_store && !flush && (!full || drain) && !rst;

   assign cpu_stall  = is_store && !rst && (flush || (full && !drain));
   assign flush_done = flush && (cnt == '0);
   assign count      = cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         cnt   <= '0;
         valid <= '0;
      end else begin
         // Clear before set: when full with simultaneous drain and enqueue,
         // head == tail and the slot must stay valid with the new store.
         if (drain) begin
            valid[head] <= 1'b0;
            head        <= head + PW'(1);
         end
         if (enq) begin
            valid[tail] <= 1'b1;
            tail        <= tail + PW'(1);
         end
         if (enq && !drain)
            cnt <= cnt + CW'(1);
         else if (drain && !enq)
            cnt <= cnt - CW'(1);
      end
   end

   // Entry payload needs no reset; valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (enq) begin
         entry_addr[tail] <= cpu_addr;
         entry_data[tail] <= cpu_wdata;
      end
   end

   sb_match #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_match (
      .head       (head),
      .valid      (valid),
      .entry_addr (entry_addr),
      .entry_data (entry_data),
      .addr       (cpu_addr),
      .hit        (fwd_hit),
      .data       (fwd_data)
   );

   assign cpu_rdata = fwd_hit ? fwd_data : mem_rdata;

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (is_load) begin
         mem_addr = cpu_addr;
      end else if (drain) begin
         mem_addr  = entry_addr[head];
         mem_wdata = entry_data[head];
         mem_we    = 1'b1;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst, cpu_req, cpu_we, flush;
   logic [XLEN-1:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic            cpu_stall, flush_done, mem_we;
   logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]      count;

   store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall), .flush(flush), .flush_done(flush_done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .count(count)
   );

   always #5 clk = ~clk;

   // Data_Mem stand-in: 32 words, combinational read, write on clk edge.
   logic            dm_load;
   logic [XLEN-1:0] dm [32];
   assign mem_rdata = (mem_addr < 64'd32) ? dm[mem_addr[4:0]] : '0;
   always @(posedge clk) begin
      if (dm_load) begin
         for (int i = 0; i < 32; i++) dm[i] <= 64'hD000 + 64'(i);
      end else if (mem_we) begin
         dm[mem_addr[4:0]] <= mem_wdata;
      end
   end

   // Reference model: ordered queue of pending stores plus memory image.
   typedef struct { logic [XLEN-1:0] a; logic [XLEN-1:0] d; } ent_t;
   ent_t            q[$];
   logic [XLEN-1:0] ref_dm [32];

   int checks = 0;
   int errors = 0;

   logic            exp_stall, exp_we, exp_fd;
   logic [XLEN-1:0] exp_rdata, exp_maddr, exp_mwdata;
   logic [2:0]      exp_count;
   logic            obs_stall, obs_we, obs_fd;
   logic [XLEN-1:0] obs_rdata, obs_maddr, obs_mwdata;
   logic [2:0]      obs_count;

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 32; i++) ref_dm[i] = 64'hD000 + 64'(i);
   endtask

   // Drive one cycle (called at negedge), predict and capture outputs,
   // then advance the model across the clock edge.
   task automatic step(input logic req, input logic we, input logic [XLEN-1:0] addr,
                       input logic [XLEN-1:0] data, input logic fl);
      logic ld, st, drn;
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = data; flush = fl;
      #1;
      ld  = req && !we;
      st  = req && we;
      drn = !ld && (q.size() > 0);
      exp_stall = st && (fl || (q.size() == DEPTH && !drn));
      exp_rdata = ref_dm[addr[4:0]];
      foreach (q[i]) if (q[i].a == addr) exp_rdata = q[i].d;
      exp_we     = drn;
      exp_maddr  = ld ? addr : (drn ? q[0].a : '0);
      exp_mwdata = drn ? q[0].d : '0;
      exp_count  = 3'(q.size());
      exp_fd     = fl && (q.size() == 0);
      obs_stall = cpu_stall; obs_rdata = cpu_rdata; obs_we = mem_we;
      obs_maddr = mem_addr;  obs_mwdata = mem_wdata; obs_count = count;
      obs_fd    = flush_done;
      if (drn) begin
         ref_dm[q[0].a[4:0]] = q[0].d;
         void'(q.pop_front());
      end
      if (st && !exp_stall) q.push_back('{a: addr, d: data});
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; dm_load = 1'b1; flush = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      @(negedge clk); @(negedge clk);
      dm_load = 1'b0;
      flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'd3;
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
      checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL reset_flush_done got %b exp 1", flush_done); end
      checks++; if (cpu_rdata !== 64'hD003) begin errors++; $display("FAIL reset_rdata got %h exp D003", cpu_rdata); end
      cpu_we = 1'b1; flush = 1'b0;
      #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done0 got %b exp 0", flush_done); end
      cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_forward();
      step(1, 1, 64'd5, 64'h11, 0);
      step(1, 0, 64'd5, '0, 0);
      checks++; if (obs_rdata !== 64'h11) begin errors++; $display("FAIL fwd_rdata got %h exp 11", obs_rdata); end
      checks++; if (obs_we !== 1'b0 || obs_maddr !== 64'd5) begin errors++; $display("FAIL fwd_load_port got we=%b addr=%h exp we=0 addr=5", obs_we, obs_maddr); end
      checks++; if (dm[5] !== 64'hD005) begin errors++; $display("FAIL fwd_dm_early got %h exp D005", dm[5]); end
      step(0, 0, '0, '0, 0);
      checks++; if (obs_we !== 1'b1 || obs_maddr !== 64'd5 || obs_mwdata !== 64'h11) begin
         errors++; $display("FAIL fwd_drain got we=%b addr=%h data=%h exp 1/5/11", obs_we, obs_maddr, obs_mwdata); end
      checks++; if (dm[5] !== 64'h11) begin errors++; $display("FAIL fwd_dm got %h exp 11", dm[5]); end
   endtask

   task automatic test_duplicate();
      step(1, 1, 64'd7, 64'hA, 0);
      step(1, 1, 64'd7, 64'hB, 0);
      step(1, 0, 64'd7, '0, 0);
      checks++; if (obs_rdata !== 64'hB) begin errors++; $display("FAIL dup_rdata got %h exp B", obs_rdata); end
      checks++; if (dm[7] !== 64'hA) begin errors++; $display("FAIL dup_dm_first got %h exp A", dm[7]); end
      step(0, 0, '0, '0, 0);
      checks++; if (dm[7] !== 64'hB) begin errors++; $display("FAIL dup_dm_final got %h exp B", dm[7]); end
   endtask

   task automatic test_back_to_back();
      for (int unsigned i = 1; i <= 4; i++) begin
         step(1, 1, 64'(i), 64'h100 + 64'(i), 0);
         step(1, 0, 64'd9, '0, 0);
         checks++; if (obs_rdata !== 64'hD009) begin errors++; $display("FAIL b2b_load9 got %h exp D009", obs_rdata); end
      end
      step(0, 0, '0, '0, 0);
      for (int unsigned i = 1; i <= 4; i++) begin
         checks++; if (dm[i] !== 64'h100 + 64'(i)) begin errors++; $display("FAIL b2b_dm%0d got %h exp %h", i, dm[i], 64'h100 + 64'(i)); end
      end
   endtask

   task automatic test_flush();
      step(1, 1, 64'd10, 64'h77, 0);
      step(1, 0, 64'd11, '0, 0);
      checks++; if (obs_count !== 3'd1) begin errors++; $display("FAIL flush_pre_count got %0d exp 1", obs_count); end
      step(1, 1, 64'd12, 64'h99, 1);
      checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL flush_stall got %b exp 1", obs_stall); end
      checks++; if (obs_we !== 1'b1 || obs_fd !== 1'b0) begin errors++; $display("FAIL flush_drain got we=%b fd=%b exp 1/0", obs_we, obs_fd); end
      step(1, 1, 64'd12, 64'h99, 1);
      checks++; if (obs_stall !== 1'b1 || obs_fd !== 1'b1 || obs_we !== 1'b0) begin
         errors++; $display("FAIL flush_empty got stall=%b fd=%b we=%b exp 1/1/0", obs_stall, obs_fd, obs_we); end
      step(1, 0, 64'd10, '0, 1);
      checks++; if (obs_rdata !== 64'h77 || obs_fd !== 1'b1) begin errors++; $display("FAIL flush_load got %h fd=%b exp 77/1", obs_rdata, obs_fd); end
      checks++; if (dm[12] !== 64'hD00C) begin errors++; $display("FAIL flush_no_write got %h exp D00C", dm[12]); end
      step(0, 0, '0, '0, 0);
   endtask

   task automatic test_reset_mid_drain();
      step(1, 1, 64'd20, 64'h55, 0);
      cpu_req = 1'b0; cpu_we = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL mid_pre_we got %b exp 1", mem_we); end
      #2 rst = 1'b1;
      #1;
      checks++; if (mem_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL mid_reset got we=%b count=%0d exp 0/0", mem_we, count); end
      @(posedge clk); #1;
      checks++; if (dm[20] !== 64'hD014) begin errors++; $display("FAIL mid_dm got %h exp D014", dm[20]); end
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      @(negedge clk);
   endtask

   task automatic test_random();
      logic req, we, fl;
      logic [XLEN-1:0] a, d;
      int unsigned guard;
      for (int n = 0; n < 400; n++) begin
         req = ($urandom_range(0, 3) != 0);
         we  = $urandom_range(0, 1) == 1;
         fl  = ($urandom_range(0, 15) == 0);
         a   = 64'($urandom_range(0, 7));
         d   = {$urandom, $urandom};
         step(req, we, a, d, fl);
         checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", n, obs_stall, exp_stall); end
         checks++; if (obs_we !== exp_we) begin errors++; $display("FAIL rnd_mem_we cyc %0d got %b exp %b", n, obs_we, exp_we); end
         checks++; if (obs_maddr !== exp_maddr || obs_mwdata !== exp_mwdata) begin
            errors++; $display("FAIL rnd_mem_port cyc %0d got %h/%h exp %h/%h", n, obs_maddr, obs_mwdata, exp_maddr, exp_mwdata); end
         checks++; if (obs_count !== exp_count) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", n, obs_count, exp_count); end
         checks++; if (obs_fd !== exp_fd) begin errors++; $display("FAIL rnd_flush_done cyc %0d got %b exp %b", n, obs_fd, exp_fd); end
         if (req && !we) begin
            checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", n, obs_rdata, exp_rdata); end
         end
      end
      guard = 0;
      while (count != 3'd0 && guard < 20) begin
         step(0, 0, '0, '0, 1);
         guard++;
      end
      checks++; if (count !== 3'd0 || flush_done !== 1'b1) begin errors++; $display("FAIL rnd_drain_timeout count=%0d fd=%b exp 0/1", count, flush_done); end
      for (int i = 0; i < 32; i++) begin
         checks++; if (dm[i] !== ref_dm[i]) begin errors++; $display("FAIL rnd_dm[%0d] got %h exp %h", i, dm[i], ref_dm[i]); end
      end
      flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_forward();
      test_duplicate();
      test_back_to_back();
      test_flush();
      test_reset_mid_drain();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
